// File: rtl/add_shift_mul_ctrl_if.sv
// rtl/add_shift_mul_ctrl_if.sv - operand/product handshake bundle for the sequential multiplier
interface add_shift_mul_ctrl_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] product;
  logic        busy;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, product, busy
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, product, busy
  );
endinterface

// File: rtl/add_shift_mul_ctrl.sv
// rtl/add_shift_mul_ctrl.sv - 32x32 unsigned shift-and-add multiplier around one ripple adder
module add_32_bit (
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  input  logic        i_cin,
  output logic [31:0] o_sum,
  output logic        o_cout
);
  logic [32:0] w_c;

  assign w_c[0] = i_cin;
  for (genvar g = 0; g < 32; g++) begin : g_fa
    assign o_sum[g]  = i_a[g] ^ i_b[g] ^ w_c[g];
    assign w_c[g+1]  = (i_a[g] & i_b[g]) | (w_c[g] & (i_a[g] ^ i_b[g]));
  end
  assign o_cout = w_c[32];
endmodule

module add_shift_mul_ctrl #(
  parameter int ZERO_BYPASS = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  add_shift_mul_ctrl_if.slave    bus
);
  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t      r_state;
  state_t      w_next;
  logic [31:0] r_m;
  logic [31:0] r_acc_hi;
  logic [31:0] r_q;
  logic [5:0]  r_cnt;
  logic [31:0] w_addend;
  logic [31:0] w_sum;
  logic        w_cout;
  logic        w_bypass;
  logic        w_accept;

  assign w_addend = r_q[0] ? r_m : 32'd0;
  assign w_bypass = (ZERO_BYPASS != 0) && ((bus.a == 32'd0) || (bus.b == 32'd0));
  assign w_accept = (r_state == S_IDLE) && bus.in_valid;

  add_32_bit u_add (
    .i_a    (r_acc_hi),
    .i_b    (w_addend),
    .i_cin  (1'b0),
    .o_sum  (w_sum),
    .o_cout (w_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next        = r_state;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.busy      = 1'b0;
    case (r_state)
      S_IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) begin
          w_next = w_bypass ? S_DONE : S_CALC;
        end
      end
      S_CALC: begin
        bus.busy = 1'b1;
        if (r_cnt == 6'd31) begin
          w_next = S_DONE;
        end
      end
      S_DONE: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) begin
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // The adder carry lands in acc_hi[31] as the pair shifts right, keeping the result exact.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_m      <= '0;
      r_acc_hi <= '0;
      r_q      <= '0;
      r_cnt    <= '0;
    end else if (w_accept) begin
      r_m      <= bus.a;
      r_acc_hi <= '0;
      r_q      <= w_bypass ? 32'd0 : bus.b;
      r_cnt    <= '0;
    end else if (r_state == S_CALC) begin
      {r_acc_hi, r_q} <= {w_cout, w_sum, r_q[31:1]};
      r_cnt           <= r_cnt + 6'd1;
    end
  end

  assign bus.product = {r_acc_hi, r_q};
endmodule

// File: tb/tb_add_shift_mul_ctrl.sv
// tb/tb_add_shift_mul_ctrl.sv - randomized and directed checks of the sequential multiplier
module tb_add_shift_mul_ctrl;
  logic        clk;
  logic        rst_n;
  logic        sel;
  logic        in_valid;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_ready;
  int          passed;
  int          total;

  add_shift_mul_ctrl_if if_byp ();
  add_shift_mul_ctrl_if if_full ();

  // sel=0 drives the ZERO_BYPASS=1 unit, sel=1 the ZERO_BYPASS=0 unit
  assign if_byp.in_valid   = in_valid & ~sel;
  assign if_byp.out_ready  = out_ready & ~sel;
  assign if_byp.a          = a;
  assign if_byp.b          = b;
  assign if_full.in_valid  = in_valid & sel;
  assign if_full.out_ready = out_ready & sel;
  assign if_full.a         = a;
  assign if_full.b         = b;

  wire        o_in_ready  = sel ? if_full.in_ready  : if_byp.in_ready;
  wire        o_out_valid = sel ? if_full.out_valid : if_byp.out_valid;
  wire        o_busy      = sel ? if_full.busy      : if_byp.busy;
  wire [63:0] o_product   = sel ? if_full.product   : if_byp.product;

  add_shift_mul_ctrl #(.ZERO_BYPASS(1)) u_byp  (.clk(clk), .rst_n(rst_n), .bus(if_byp));
  add_shift_mul_ctrl #(.ZERO_BYPASS(0)) u_full (.clk(clk), .rst_n(rst_n), .bus(if_full));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_in_ready"}, 64'(o_in_ready), 64'd1);
    chk({tag, "_out_valid"}, 64'(o_out_valid), 64'd0);
    chk({tag, "_busy"}, 64'(o_busy), 64'd0);
    chk({tag, "_product"}, o_product, 64'd0);
  endtask

  // Full transaction: accept, measure latency/busy time, hold under backpressure, release.
  task automatic mul_op(input logic s, input logic [31:0] av, input logic [31:0] bv, input int stall);
    logic [63:0] exp_p;
    int          exp_lat;
    int          edges;
    int          busy_cnt;
    exp_p   = {32'd0, av} * {32'd0, bv};
    exp_lat = (!s && (av == 32'd0 || bv == 32'd0)) ? 1 : 33;
    sel       = s;
    out_ready = (stall == 0);
    a         = av;
    b         = bv;
    in_valid  = 1'b1;
    #1;
    chk("accept_in_ready", 64'(o_in_ready), 64'd1);
    step();
    in_valid = 1'b0;
    a        = $urandom;
    b        = $urandom;
    edges    = 1;
    busy_cnt = 0;
    while (!o_out_valid && edges < 100) begin
      if (o_busy) busy_cnt++;
      step();
      edges++;
    end
    chk("latency", 64'(edges), 64'(exp_lat));
    chk("busy_cycles", 64'(busy_cnt), 64'(exp_lat - 1));
    chk("product", o_product, exp_p);
    chk("done_in_ready", 64'(o_in_ready), 64'd0);
    if (stall > 0) begin
      in_valid = 1'b1;
      for (int i = 0; i < stall; i++) begin
        step();
        chk("stall_valid", 64'(o_out_valid), 64'd1);
        chk("stall_product", o_product, exp_p);
        chk("stall_in_ready", 64'(o_in_ready), 64'd0);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
    end
    step();
    chk("release_valid", 64'(o_out_valid), 64'd0);
    chk("release_in_ready", 64'(o_in_ready), 64'd1);
  endtask

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    passed    = 0;
    total     = 0;
    rst_n     = 1'b0;
    sel       = 1'b0;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    step();
    check_reset_outputs("reset_byp");
    sel = 1'b1;
    #1;
    check_reset_outputs("reset_full");
    step();

    mul_op(1'b1, 32'd3, 32'd5, 0);
    mul_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    mul_op(1'b1, 32'h8000_0000, 32'd2, 0);
    mul_op(1'b0, 32'd0, 32'h1234, 0);
    mul_op(1'b1, 32'd0, 32'h1234, 0);
    mul_op(1'b0, 32'd7, 32'd6, 10);
    mul_op(1'b0, 32'd9, 32'd11, 0);

    // Asynchronous reset in the middle of iteration 15
    sel       = 1'b1;
    out_ready = 1'b1;
    a         = 32'h1234_5678;
    b         = 32'h9ABC_DEF0;
    in_valid  = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (15) step();
    chk("pre_reset_busy", 64'(o_busy), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    #3;
    rst_n = 1'b1;
    step();
    check_reset_outputs("post_reset");
    mul_op(1'b1, 32'h1234_5678, 32'h9ABC_DEF0, 0);
    chk("spec_vector", {32'd0, 32'h1234_5678} * {32'd0, 32'h9ABC_DEF0}, 64'h0B00_EA4E_242D_2080);

    for (int n = 0; n < 10; n++) begin
      ra = $urandom;
      rb = $urandom;
      if ($urandom_range(0, 3) == 0) ra = 32'd0;
      if ($urandom_range(0, 3) == 0) rb = 32'd0;
      mul_op(1'($urandom_range(0, 1)), ra, rb, int'($urandom_range(0, 3)));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
